// File: rtl/sd_cmd_tx.sv
// SD card command-line transmitter: serialises a 48-bit CMD frame with a serially computed CRC7.
// Define SD_CMD_TX_NCC_EN to keep driving the line high for 8 extra bit periods (NCC) after the end bit.
`timescale 1ns/1ps

module sd_cmd_tx (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_clk_en,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] argument,
  output logic        sd_cmd_out,
  output logic        sd_cmd_oe,
  output logic        busy,
  output logic        done
);

`ifdef SD_CMD_TX_NCC_EN
  typedef enum logic [1:0] {IDLE, WAIT_FIRST, SEND, NCC} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT_FIRST, SEND} state_t;
`endif

  state_t      r_state;
  state_t      w_nextState;
  logic [39:0] r_shift;
  logic [6:0]  r_crc;
  logic [5:0]  r_bitCnt;
  logic        r_cmdOut;
  logic        r_cmdOe;
  logic        r_done;

  logic        w_accept;
  logic        w_tick;
  logic        w_finish;
  logic        w_bitOut;
  logic        w_feedback;
  logic [6:0]  w_crcNext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // w_tick: a line bit is emitted on this strobe; w_finish: release the line and pulse done
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_tick      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = WAIT_FIRST;
        end
      end
      WAIT_FIRST: begin
        if (sd_clk_en) begin
          w_tick      = 1'b1;
          w_nextState = SEND;
        end
      end
      SEND: begin
        if (sd_clk_en) begin
          if (r_bitCnt == 6'd48) begin
`ifdef SD_CMD_TX_NCC_EN
            w_tick      = 1'b1;
            w_nextState = NCC;
`else
            w_finish    = 1'b1;
            w_nextState = IDLE;
`endif
          end else begin
            w_tick = 1'b1;
          end
        end
      end
`ifdef SD_CMD_TX_NCC_EN
      NCC: begin
        if (sd_clk_en) begin
          if (r_bitCnt == 6'd56) begin
            w_finish    = 1'b1;
            w_nextState = IDLE;
          end else begin
            w_tick = 1'b1;
          end
        end
      end
`endif
      default: w_nextState = IDLE;
    endcase
  end

  // Header/payload bits feed the CRC; CRC bits then shift out of the CRC register itself
  assign w_feedback = r_shift[39] ^ r_crc[6];
  assign w_crcNext  = {r_crc[5:0], 1'b0} ^ (w_feedback ? 7'h09 : 7'h00);
  assign w_bitOut   = (r_bitCnt < 6'd40) ? r_shift[39] :
                      (r_bitCnt < 6'd47) ? r_crc[6]    : 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift  <= '0;
      r_crc    <= '0;
      r_bitCnt <= '0;
      r_cmdOut <= 1'b1;
      r_cmdOe  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_shift  <= {2'b01, cmd_index, argument};
        r_crc    <= '0;
        r_bitCnt <= '0;
      end else if (w_tick) begin
        r_cmdOut <= w_bitOut;
        r_cmdOe  <= 1'b1;
        r_bitCnt <= r_bitCnt + 6'd1;
        if (r_bitCnt < 6'd40) begin
          r_shift <= {r_shift[38:0], 1'b0};
          r_crc   <= w_crcNext;
        end else if (r_bitCnt < 6'd47) begin
          r_crc <= {r_crc[5:0], 1'b0};
        end
      end else if (w_finish) begin
        r_cmdOut <= 1'b1;
        r_cmdOe  <= 1'b0;
      end
    end
  end

  assign sd_cmd_out = r_cmdOut;
  assign sd_cmd_oe  = r_cmdOe;
  assign done       = r_done;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Directed testbench for sd_cmd_tx: known CMD frames, ignored mid-frame start, coincident start,
// irregular strobes, mid-frame reset and back-to-back frames (NCC tail when SD_CMD_TX_NCC_EN is defined).
`timescale 1ns/1ps

module tb_sd_cmd_tx;

`ifdef SD_CMD_TX_NCC_EN
  localparam int FRAME_END = 56;
`else
  localparam int FRAME_END = 48;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sd_clk_en = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] argument = '0;
  logic        sd_cmd_out;
  logic        sd_cmd_oe;
  logic        busy;
  logic        done;

  int nChecks = 0;
  int nErrors = 0;

  logic        capOut [0:63];
  logic        capOe  [0:63];
  logic [47:0] capFrame;
  logic [7:0]  nccBits;
  int          doneStrobe;
  int          doneCount;
  int          holdBad;
  int          oeLow;
  logic        busyAtDone;

  sd_cmd_tx dut (
    .clk        (clk),
    .reset      (reset),
    .sd_clk_en  (sd_clk_en),
    .start      (start),
    .cmd_index  (cmd_index),
    .argument   (argument),
    .sd_cmd_out (sd_cmd_out),
    .sd_cmd_oe  (sd_cmd_oe),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation exceeded time limit (errors=%0d)", nErrors);
    $fatal(1, "timeout");
  end

  // Inputs change and outputs are sampled 1ns after the rising edge
  task automatic startCmd(input logic [5:0] cmd, input logic [31:0] arg, input logic coincident);
    cmd_index = cmd;
    argument  = arg;
    start     = 1'b1;
    sd_clk_en = coincident;
    @(posedge clk); #1;
    start     = 1'b0;
    sd_clk_en = 1'b0;
  endtask

  // Issues n strobes, recording line state after each; no idle cycles follow the last strobe
  task automatic runStrobes(input int n, input logic irregular, input int injectAt);
    int gap;
    capFrame   = '0;
    nccBits    = '0;
    doneStrobe = -1;
    doneCount  = 0;
    holdBad    = 0;
    oeLow      = 0;
    busyAtDone = 1'b1;
    for (int k = 0; k < n; k++) begin
      gap = irregular ? (((k * 5 + 3) % 7) + 1) : 4;
      if (k == n - 1) gap = 1;
      sd_clk_en = 1'b1;
      if (k == injectAt) begin
        start     = 1'b1;
        cmd_index = 6'd55;
        argument  = 32'hFFFF_FFFF;
      end
      @(posedge clk); #1;
      sd_clk_en = 1'b0;
      start     = 1'b0;
      capOut[k] = sd_cmd_out;
      capOe[k]  = sd_cmd_oe;
      if (k < 48) capFrame = {capFrame[46:0], sd_cmd_out};
      else if (k < 56) nccBits = {nccBits[6:0], sd_cmd_out};
      if (k < FRAME_END && sd_cmd_oe !== 1'b1) oeLow++;
      if (done === 1'b1) begin
        doneCount++;
        if (doneStrobe < 0) begin
          doneStrobe = k;
          busyAtDone = busy;
        end
      end
      for (int g = 1; g < gap; g++) begin
        @(posedge clk); #1;
        if (done === 1'b1) doneCount++;
        if (sd_cmd_out !== capOut[k] || sd_cmd_oe !== capOe[k]) holdBad++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nChecks++;
    if ({sd_cmd_out, sd_cmd_oe, busy, done} !== 4'b1000) begin
      nErrors++;
      $display("FAIL reset_outputs: got {out,oe,busy,done}=%b expected 1000", {sd_cmd_out, sd_cmd_oe, busy, done});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    nChecks++;
    if ({sd_cmd_out, sd_cmd_oe, busy} !== 3'b100) begin
      nErrors++;
      $display("FAIL idle_after_reset: got {out,oe,busy}=%b expected 100", {sd_cmd_out, sd_cmd_oe, busy});
    end
  endtask

  task automatic test_cmd0();
    startCmd(6'd0, 32'h0000_0000, 1'b0);
    nChecks++;
    if ({busy, sd_cmd_oe} !== 2'b10) begin
      nErrors++;
      $display("FAIL cmd0_busy_after_start: got {busy,oe}=%b expected 10", {busy, sd_cmd_oe});
    end
    runStrobes(FRAME_END + 3, 1'b0, -1);
    nChecks++;
    if (capFrame !== 48'h4000_0000_0095) begin
      nErrors++;
      $display("FAIL cmd0_frame: got %012h expected 400000000095", capFrame);
    end
    nChecks++;
    if (doneStrobe !== FRAME_END || doneCount !== 1) begin
      nErrors++;
      $display("FAIL cmd0_done: got strobe %0d count %0d expected strobe %0d count 1", doneStrobe, doneCount, FRAME_END);
    end
    nChecks++;
    if (busyAtDone !== 1'b0) begin
      nErrors++;
      $display("FAIL cmd0_busy_at_done: got %b expected 0", busyAtDone);
    end
    nChecks++;
    if (oeLow !== 0 || holdBad !== 0) begin
      nErrors++;
      $display("FAIL cmd0_oe_hold: got oeLow=%0d holdBad=%0d expected 0 and 0", oeLow, holdBad);
    end
    nChecks++;
    if ({capOut[FRAME_END], capOe[FRAME_END]} !== 2'b10) begin
      nErrors++;
      $display("FAIL cmd0_release: got {out,oe}=%b expected 10", {capOut[FRAME_END], capOe[FRAME_END]});
    end
`ifdef SD_CMD_TX_NCC_EN
    nChecks++;
    if (nccBits !== 8'hFF) begin
      nErrors++;
      $display("FAIL cmd0_ncc_bits: got %02h expected ff", nccBits);
    end
`endif
  endtask

  task automatic test_cmd8();
    startCmd(6'd8, 32'h0000_01AA, 1'b0);
    runStrobes(FRAME_END + 3, 1'b0, -1);
    nChecks++;
    if (capFrame !== 48'h4800_0001_AA87) begin
      nErrors++;
      $display("FAIL cmd8_frame: got %012h expected 48000001aa87", capFrame);
    end
    nChecks++;
    if (doneStrobe !== FRAME_END || doneCount !== 1) begin
      nErrors++;
      $display("FAIL cmd8_done: got strobe %0d count %0d expected strobe %0d count 1", doneStrobe, doneCount, FRAME_END);
    end
  endtask

  task automatic test_ignore_start();
    startCmd(6'd17, 32'h0000_0000, 1'b0);
    runStrobes(FRAME_END + 3, 1'b0, 20);
    nChecks++;
    if (capFrame !== 48'h5100_0000_0055) begin
      nErrors++;
      $display("FAIL cmd17_frame: got %012h expected 510000000055", capFrame);
    end
    nChecks++;
    if (doneCount !== 1 || doneStrobe !== FRAME_END) begin
      nErrors++;
      $display("FAIL cmd17_done: got strobe %0d count %0d expected strobe %0d count 1", doneStrobe, doneCount, FRAME_END);
    end
    nChecks++;
    if (busy !== 1'b0) begin
      nErrors++;
      $display("FAIL cmd17_idle_after: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_coincident_irregular();
    startCmd(6'd0, 32'h0000_0000, 1'b1);
    nChecks++;
    if ({busy, sd_cmd_oe, sd_cmd_out} !== 3'b101) begin
      nErrors++;
      $display("FAIL coincident_latch_only: got {busy,oe,out}=%b expected 101", {busy, sd_cmd_oe, sd_cmd_out});
    end
    runStrobes(FRAME_END + 3, 1'b1, -1);
    nChecks++;
    if (capFrame !== 48'h4000_0000_0095) begin
      nErrors++;
      $display("FAIL irregular_frame: got %012h expected 400000000095", capFrame);
    end
    nChecks++;
    if (holdBad !== 0 || doneStrobe !== FRAME_END || doneCount !== 1) begin
      nErrors++;
      $display("FAIL irregular_timing: got holdBad=%0d strobe %0d count %0d expected 0, %0d, 1", holdBad, doneStrobe, doneCount, FRAME_END);
    end
  endtask

  task automatic test_reset_midframe();
    startCmd(6'd17, 32'h0000_0000, 1'b0);
    runStrobes(21, 1'b0, -1);
    nChecks++;
    if (capOe[20] !== 1'b1) begin
      nErrors++;
      $display("FAIL midframe_driving: got oe=%b expected 1", capOe[20]);
    end
    #2;
    reset = 1'b0;
    #1;
    nChecks++;
    if ({sd_cmd_oe, sd_cmd_out, busy, done} !== 4'b0100) begin
      nErrors++;
      $display("FAIL midframe_async_release: got {oe,out,busy,done}=%b expected 0100", {sd_cmd_oe, sd_cmd_out, busy, done});
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    runStrobes(10, 1'b0, -1);
    nChecks++;
    if (oeLow !== 10 || doneCount !== 0 || busy !== 1'b0) begin
      nErrors++;
      $display("FAIL no_resume: got oeLow=%0d done=%0d busy=%b expected 10, 0, 0", oeLow, doneCount, busy);
    end
    startCmd(6'd0, 32'h0000_0000, 1'b0);
    runStrobes(FRAME_END + 3, 1'b0, -1);
    nChecks++;
    if (capFrame !== 48'h4000_0000_0095 || doneCount !== 1) begin
      nErrors++;
      $display("FAIL post_reset_cmd0: got %012h done=%0d expected 400000000095 done=1", capFrame, doneCount);
    end
  endtask

  task automatic test_back_to_back();
    startCmd(6'd17, 32'h0000_0000, 1'b0);
    runStrobes(FRAME_END + 1, 1'b0, -1);
    nChecks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      nErrors++;
      $display("FAIL b2b_first_done: got done=%b busy=%b expected 1 0", done, busy);
    end
    startCmd(6'd8, 32'h0000_01AA, 1'b0);
    nChecks++;
    if ({busy, done} !== 2'b10) begin
      nErrors++;
      $display("FAIL b2b_restart: got {busy,done}=%b expected 10", {busy, done});
    end
    runStrobes(FRAME_END + 3, 1'b0, -1);
    nChecks++;
    if (capFrame !== 48'h4800_0001_AA87 || doneCount !== 1) begin
      nErrors++;
      $display("FAIL b2b_second_frame: got %012h done=%0d expected 48000001aa87 done=1", capFrame, doneCount);
    end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_ignore_start();
    test_coincident_irregular();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
